// File: rtl/symbol_mapper_arbiter.sv
// Round-robin arbiter sharing one symbol mapper between decoder lanes.
// One mapper request in flight; results or timeouts go back to the granted lane.
module symbol_mapper_arbiter #(
  parameter int N_LANES        = 4,
  parameter int TIMEOUT_CYCLES = 15,
  parameter int ERR_CNT_W      = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_LANES-1:0]     req_valid,
  input  logic [16*N_LANES-1:0]  req_range,
  output logic [N_LANES-1:0]     req_ready,
  output logic                   map_en,
  output logic [15:0]            map_range,
  input  logic [15:0]            map_symbol,
  input  logic                   map_valid,
  input  logic                   map_error,
  output logic [N_LANES-1:0]     rsp_valid,
  output logic [15:0]            rsp_symbol,
  output logic                   rsp_error,
  output logic                   rsp_timeout,
  input  logic [N_LANES-1:0]     rsp_ready,
  output logic                   busy,
  output logic [ERR_CNT_W-1:0]   err_count
);

  localparam int LW = $clog2(N_LANES);
  localparam int CW = $clog2(TIMEOUT_CYCLES);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ISSUE   = 2'd1;
  localparam logic [1:0] WAIT    = 2'd2;
  localparam logic [1:0] RESPOND = 2'd3;

  logic [1:0]    state;
  logic [LW-1:0] rr_ptr;
  logic [LW-1:0] lane;
  logic [LW-1:0] grant;
  logic [LW-1:0] grant_nxt;
  logic [LW-1:0] idx;
  logic          grant_ok;
  logic [CW-1:0] wait_cnt;
  logic          fail;
  logic [15:0]   lane_range [N_LANES];

  for (genvar i = 0; i < N_LANES; i++) begin : g_lane
    assign lane_range[i] = req_range[16*i +: 16];
  end

  // Search starts at rr_ptr and wraps; the first valid lane wins.
  always_comb begin
    grant    = '0;
    grant_ok = 1'b0;
    idx      = rr_ptr;
    for (int k = 0; k < N_LANES; k++) begin
      if (!grant_ok && req_valid[idx]) begin
        grant    = idx;
        grant_ok = 1'b1;
      end
      idx = (idx == LW'(N_LANES-1)) ? '0 : idx + LW'(1);
    end
  end

  assign grant_nxt =
    (grant == LW'(N_LANES-1)) ? '0 : grant + LW'(1);

  always_comb begin
    req_ready = '0;
    if (!reset && state == IDLE && grant_ok) begin
      req_ready[grant] = 1'b1;
    end
  end

  assign busy = (state != IDLE);

  // Error wins over valid; silence past the budget is a timeout.
  assign fail = map_error || !map_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      rr_ptr      <= '0;
      lane        <= '0;
      wait_cnt    <= '0;
      map_en      <= 1'b0;
      map_range   <= '0;
      rsp_valid   <= '0;
      rsp_symbol  <= '0;
      rsp_error   <= 1'b0;
      rsp_timeout <= 1'b0;
      err_count   <= '0;
    end else begin
      map_en <= 1'b0;
      unique case (state)
        IDLE: begin
          if (grant_ok) begin
            map_range <= lane_range[grant];
            lane      <= grant;
            rr_ptr    <= grant_nxt;
            map_en    <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          wait_cnt <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          wait_cnt <= wait_cnt + CW'(1);
          if (map_error || map_valid ||
              wait_cnt == CW'(TIMEOUT_CYCLES-1)) begin
            state       <= RESPOND;
            rsp_valid   <= N_LANES'(1) << lane;
            rsp_error   <= fail;
            rsp_timeout <= !map_error && !map_valid;
            rsp_symbol  <= fail ? 16'h0 : map_symbol;
            if (fail && err_count != '1) begin
              err_count <= err_count + ERR_CNT_W'(1);
            end
          end
        end
        RESPOND: begin
          if (rsp_ready[lane]) begin
            rsp_valid   <= '0;
            rsp_symbol  <= '0;
            rsp_error   <= 1'b0;
            rsp_timeout <= 1'b0;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_symbol_mapper_arbiter.sv
// Scoreboard bench for symbol_mapper_arbiter with a behavioural mapper.
// Error counter narrowed to 4 bits so saturation is reachable quickly.
module tb_symbol_mapper_arbiter;
  localparam int N  = 4;
  localparam int EW = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [N-1:0]  req_valid;
  logic [16*N-1:0] req_range;
  logic [N-1:0]  req_ready;
  logic          map_en;
  logic [15:0]   map_range;
  logic [15:0]   map_symbol;
  logic          map_valid;
  logic          map_error;
  logic [N-1:0]  rsp_valid;
  logic [15:0]   rsp_symbol;
  logic          rsp_error;
  logic          rsp_timeout;
  logic [N-1:0]  rsp_ready;
  logic          busy;
  logic [EW-1:0] err_count;

  symbol_mapper_arbiter #(
    .N_LANES(N),
    .TIMEOUT_CYCLES(15),
    .ERR_CNT_W(EW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_range(req_range),
    .req_ready(req_ready),
    .map_en(map_en),
    .map_range(map_range),
    .map_symbol(map_symbol),
    .map_valid(map_valid),
    .map_error(map_error),
    .rsp_valid(rsp_valid),
    .rsp_symbol(rsp_symbol),
    .rsp_error(rsp_error),
    .rsp_timeout(rsp_timeout),
    .rsp_ready(rsp_ready),
    .busy(busy),
    .err_count(err_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0]  vld;
    logic [15:0]   sym;
    logic          err;
    logic          to;
    logic [EW-1:0] cnt;
  } rsp_t;

  rsp_t        exp_rsp [$];
  int          exp_grant [$];
  logic [15:0] exp_range [$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int t_en = 0;
  int exp_lat = -1;
  int grant_cnt = 0;
  logic [EW-1:0] exp_err = '0;

  int mode = 0;
  int mdelay = 1;
  logic [15:0] msym = '0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d",
               name, act, req, cyc);
    end
  endtask

  // Mapper model: mode 0 answers valid, mode 1 answers valid+error,
  // mode 3 stays silent; answer comes mdelay cycles after map_en.
  initial begin
    int m;
    int d;
    map_valid  = 1'b0;
    map_error  = 1'b0;
    map_symbol = '0;
    forever begin
      @(negedge clk);
      if (map_en && !reset && mode != 3) begin
        m = mode;
        d = mdelay;
        repeat (d) @(negedge clk);
        map_valid  = 1'b1;
        map_error  = (m == 1);
        map_symbol = msym;
        @(negedge clk);
        map_valid  = 1'b0;
        map_error  = 1'b0;
      end
    end
  end

  logic [N-1:0] p_rv = '0;
  logic [15:0]  p_sym = '0;
  logic         p_err = 1'b0;
  logic         p_to = 1'b0;
  logic         p_hold = 1'b0;
  logic         p_en = 1'b0;
  logic         hs;
  rsp_t         mon_e;

  always @(negedge clk) begin
    #1;
    cyc++;
    if (reset) begin
      p_rv   = '0;
      p_hold = 1'b0;
      p_en   = 1'b0;
    end else begin
      chk("req_ready_onehot", 32'($onehot0(req_ready)), 1);
      if (busy) chk("req_ready_busy", 32'(req_ready), 0);
      if ((req_ready & req_valid) != '0) begin
        grant_cnt++;
        if (exp_grant.size() == 0)
          chk("grant_unexpected", 32'(req_ready), 0);
        else
          chk("grant", 32'(req_ready), 32'(1) << exp_grant.pop_front());
      end
      if (map_en) begin
        t_en = cyc;
        chk("map_en_width", 32'(p_en), 0);
        if (exp_range.size() == 0)
          chk("map_unexpected", 32'(map_en), 0);
        else
          chk("map_range", 32'(map_range), 32'(exp_range.pop_front()));
      end
      p_en = map_en;
      if (p_hold) begin
        chk("hold_valid", 32'(rsp_valid), 32'(p_rv));
        chk("hold_symbol", 32'(rsp_symbol), 32'(p_sym));
        chk("hold_error", 32'(rsp_error), 32'(p_err));
        chk("hold_timeout", 32'(rsp_timeout), 32'(p_to));
      end
      if (rsp_valid != '0 && p_rv == '0 && exp_lat >= 0)
        chk("latency", 32'(cyc - t_en), 32'(exp_lat));
      hs = (rsp_valid & rsp_ready) != '0;
      if (hs) begin
        if (exp_rsp.size() == 0) begin
          chk("rsp_unexpected", 32'(rsp_valid), 0);
        end else begin
          mon_e = exp_rsp.pop_front();
          chk("rsp_valid", 32'(rsp_valid), 32'(mon_e.vld));
          chk("rsp_symbol", 32'(rsp_symbol), 32'(mon_e.sym));
          chk("rsp_error", 32'(rsp_error), 32'(mon_e.err));
          chk("rsp_timeout", 32'(rsp_timeout), 32'(mon_e.to));
          chk("err_count", 32'(err_count), 32'(mon_e.cnt));
        end
      end
      p_hold = (rsp_valid != '0) && !hs;
      p_rv   = rsp_valid;
      p_sym  = rsp_symbol;
      p_err  = rsp_error;
      p_to   = rsp_timeout;
    end
  end

  task automatic push(int ln, logic [15:0] rng, logic [15:0] sym,
                      logic err, logic to);
    rsp_t e;
    exp_grant.push_back(ln);
    exp_range.push_back(rng);
    if (err && exp_err != '1) exp_err = exp_err + EW'(1);
    e.vld = N'(1) << ln;
    e.sym = sym;
    e.err = err;
    e.to  = to;
    e.cnt = exp_err;
    exp_rsp.push_back(e);
  endtask

  task automatic wait_grants(int g0, int n);
    for (int i = 0; i < 200 && grant_cnt < g0 + n; i++) @(negedge clk);
    if (grant_cnt < g0 + n) chk("grant_timeout", 32'(grant_cnt), 32'(g0 + n));
  endtask

  task automatic issue(int ln, logic [15:0] rng);
    int g0;
    g0 = grant_cnt;
    req_range[16*ln +: 16] = rng;
    req_valid[ln] = 1'b1;
    wait_grants(g0, 1);
    req_valid[ln] = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200 && (exp_rsp.size() != 0 || busy); i++)
      @(negedge clk);
    if (exp_rsp.size() != 0 || busy)
      chk("drain_timeout", 32'(exp_rsp.size()) + 32'(busy), 0);
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_map_en"}, 32'(map_en), 0);
    chk({tag, "_map_range"}, 32'(map_range), 0);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_rsp_symbol"}, 32'(rsp_symbol), 0);
    chk({tag, "_rsp_error"}, 32'(rsp_error), 0);
    chk({tag, "_rsp_timeout"}, 32'(rsp_timeout), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask

  initial begin
    int g0;
    reset     = 1'b1;
    req_valid = '0;
    req_range = '0;
    rsp_ready = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check_zero("reset");

    // Single request on lane 1.
    rsp_ready = '1;
    mode = 0; mdelay = 3; msym = 16'h0042; exp_lat = 4;
    push(1, 16'h0123, 16'h0042, 1'b0, 1'b0);
    issue(1, 16'h0123);
    wait_idle();

    // All lanes requesting continuously from a fresh pointer.
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_err = '0;
    mode = 0; mdelay = 1; msym = 16'h0777; exp_lat = -1;
    push(0, 16'h1000, 16'h0777, 1'b0, 1'b0);
    push(1, 16'h1001, 16'h0777, 1'b0, 1'b0);
    push(2, 16'h1002, 16'h0777, 1'b0, 1'b0);
    push(3, 16'h1003, 16'h0777, 1'b0, 1'b0);
    push(0, 16'h1000, 16'h0777, 1'b0, 1'b0);
    push(1, 16'h1001, 16'h0777, 1'b0, 1'b0);
    req_range = {16'h1003, 16'h1002, 16'h1001, 16'h1000};
    g0 = grant_cnt;
    req_valid = '1;
    wait_grants(g0, 6);
    req_valid = '0;
    wait_idle();

    // Error and valid together: error wins, symbol forced to 0.
    mode = 1; mdelay = 1; msym = 16'h0BAD; exp_lat = 2;
    push(0, 16'h2222, 16'h0000, 1'b1, 1'b0);
    issue(0, 16'h2222);
    wait_idle();

    // Silent mapper on lane 3, held response, late valid, pending lane 1.
    mode = 0; mdelay = 17; msym = 16'h5555; exp_lat = 16;
    rsp_ready = 4'b0111;
    push(3, 16'h3333, 16'h0000, 1'b1, 1'b1);
    push(1, 16'h4444, 16'h0042, 1'b0, 1'b0);
    issue(3, 16'h3333);
    req_range[16*1 +: 16] = 16'h4444;
    req_valid[1] = 1'b1;
    for (int i = 0; i < 40 && rsp_valid == '0; i++) @(negedge clk);
    chk("timeout_rsp_seen", 32'(rsp_valid), 32'(4'b1000));
    repeat (5) @(negedge clk);
    mode = 0; mdelay = 2; msym = 16'h0042; exp_lat = 3;
    g0 = grant_cnt;
    rsp_ready = '1;
    wait_grants(g0, 1);
    req_valid[1] = 1'b0;
    wait_idle();

    // Reset while waiting; the late answer must be ignored.
    mode = 0; mdelay = 6; msym = 16'h6666; exp_lat = -1;
    push(2, 16'h7777, 16'h6666, 1'b0, 1'b0);
    issue(2, 16'h7777);
    repeat (2) @(negedge clk);
    chk("busy_in_wait", 32'(busy), 1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    exp_rsp.delete();
    exp_err = '0;
    check_zero("midreset");
    repeat (8) @(negedge clk);
    chk("late_ignored_busy", 32'(busy), 0);
    chk("late_ignored_rsp", 32'(rsp_valid), 0);

    // Pointer back at lane 0 after reset.
    mode = 0; mdelay = 1; msym = 16'h6666;
    push(0, 16'h8880, 16'h6666, 1'b0, 1'b0);
    req_range = {16'h8883, 16'h8882, 16'h8881, 16'h8880};
    g0 = grant_cnt;
    req_valid = '1;
    wait_grants(g0, 1);
    req_valid = '0;
    wait_idle();

    // Saturate the error counter.
    mode = 1; mdelay = 1; msym = 16'h0BAD;
    for (int i = 0; i < 17; i++) begin
      push(0, 16'h0100 + 16'(i), 16'h0000, 1'b1, 1'b0);
      issue(0, 16'h0100 + 16'(i));
      wait_idle();
    end
    chk("err_saturated", 32'(err_count), 32'(4'hF));
    chk("queues_empty",
        32'(exp_rsp.size() + exp_grant.size() + exp_range.size()), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

endmodule
